qbus_ram_ctl: RTL



---
 rtl/qbus_pkg.sv | 23 ++
 rtl/qbus_ram_sp.sv | 34 +++
 rtl/qbus_ram_ctl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/qbus_pkg.sv
// Shared definitions for the Q-bus RAM controller: FSM states, well-known
// octal bus addresses and the byte-lane enable helper.
package qbus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        REPLY
    } state_t;

    localparam logic [15:0] PSW_ADDR = 16'o177776;
    localparam logic [15:0] VEC_TRAP = 16'o000034;

    // Word access enables both lanes; byte access picks the lane by addr[0].
    function automatic logic [1:0] byte_lane_be(input logic wtbt, input logic a0);
        if (!wtbt) begin
            return 2'b11;
        end
        return a0 ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/qbus_ram_sp.sv
// Single-port synchronous RAM, 16-bit words with two byte-lane write enables
// and a registered read port that only updates when re is high.
module qbus_ram_sp #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic [1:0]        be,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       q
);

    logic [15:0] mem_q [0:(1 << ADDR_W) - 1];
    logic [15:0] q_q;

    always_ff @(posedge clk) begin
        if (we) begin
            if (be[0]) begin
                mem_q[addr][7:0] <= wdata[7:0];
            end
            if (be[1]) begin
                mem_q[addr][15:8] <= wdata[15:8];
            end
        end
        if (re) begin
            q_q <= mem_q[addr];
        end
    end

    assign q = q_q;

endmodule

// File: rtl/qbus_ram_ctl.sv
// Q-bus slave memory controller: decodes one A15 half, inserts wait states,
// performs word/byte accesses on a single-port RAM and replies with rply_o.
module qbus_ram_ctl
    import qbus_pkg::*;
#(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned SEL_A15 = 0,
    parameter int unsigned WAIT_RD = 0,
    parameter int unsigned WAIT_WR = 0
) (
    input  logic        mclk,
    input  logic        mreset,
    input  logic [15:0] addr_i,
    input  logic [15:0] data_i,
    output logic [15:0] data_o,
    input  logic        sync_i,
    input  logic        din_i,
    input  logic        dout_i,
    input  logic        wtbt_i,
    input  logic        init_i,
    output logic        rply_o
);

    localparam logic [3:0] WAIT_RD_C = 4'(WAIT_RD);
    localparam logic [3:0] WAIT_WR_C = 4'(WAIT_WR);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                lane_q, lane_d;
    logic                wtbt_q, wtbt_d;
    logic                wr_q, wr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                rply_q, rply_d;

    logic                sel, req, req_wr;
    logic [3:0]          wait_n;
    logic                ram_we, ram_re;
    logic [15:0]         ram_q, ram_wdata, rd_fmt;

    assign sel    = (addr_i[15] == 1'(SEL_A15));
    assign req    = sync_i & sel & (din_i | dout_i);
    assign req_wr = dout_i & ~din_i;
    assign wait_n = req_wr ? WAIT_WR_C : WAIT_RD_C;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        wtbt_d  = wtbt_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rply_d  = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr_i[ADDR_W:1];
                    lane_d  = addr_i[0];
                    wtbt_d  = wtbt_i;
                    wr_d    = req_wr;
                    wdata_d = data_i;
                    if (wait_n == 4'd0) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = wait_n;
                    end
                end
            end
            WAIT: begin
                // Leave on the cycle the count would reach zero so the total
                // delay before ACCESS equals the programmed wait count.
                if (!sync_i) begin
                    state_d = IDLE;
                end else if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                if (!sync_i) begin
                    state_d = IDLE;
                end else begin
                    ram_we  = wr_q;
                    ram_re  = ~wr_q;
                    rply_d  = 1'b1;
                    state_d = REPLY;
                end
            end
            REPLY: begin
                if (!sync_i) begin
                    state_d = IDLE;
                end else begin
                    rply_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (init_i) begin
            state_d = IDLE;
            rply_d  = 1'b0;
            ram_we  = 1'b0;
            ram_re  = 1'b0;
        end
    end

    always_ff @(posedge mclk or posedge mreset) begin
        if (mreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            lane_q  <= 1'b0;
            wtbt_q  <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rply_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            wtbt_q  <= wtbt_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rply_q  <= rply_d;
        end
    end

    assign ram_wdata = wtbt_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;

    qbus_ram_sp #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (mclk),
        .we   (ram_we),
        .be   (byte_lane_be(wtbt_q, lane_q)),
        .re   (ram_re),
        .addr (addr_q),
        .wdata(ram_wdata),
        .q    (ram_q)
    );

    // Read data comes only from flops (RAM q and latched lane/size), gated by
    // the registered reply, so it clears asynchronously with reset.
    always_comb begin
        rd_fmt = ram_q;
        if (wtbt_q) begin
            rd_fmt = {8'h00, lane_q ? ram_q[15:8] : ram_q[7:0]};
        end
    end

    assign data_o = (rply_q && !wr_q) ? rd_fmt : '0;
    assign rply_o = rply_q;

endmodule
